// File: rtl/lamp_monitor.sv
// Protocol monitor for the one-hot lamp code: decodes phase, tracks dwell and completed cycles,
// flags code/sequence/stuck errors. Define LAMP_MON_STICKY_EN to make error flags hold until rst.
module lamp_monitor #(
    parameter int unsigned MAX_DWELL = 4,
    parameter int unsigned DW_W      = 8,
    parameter int unsigned CNT_W     = 8,
    parameter logic [2:0]  RED       = 3'b001,
    parameter logic [2:0]  GREEN     = 3'b010,
    parameter logic [2:0]  YELLOW    = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    output logic [1:0]       phase,
    output logic             in_sync,
    output logic [DW_W-1:0]  dwell,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             code_err,
    output logic             seq_err,
    output logic             stuck_err
);

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    phase_e           phase_q, phase_d;
    logic             in_sync_q, in_sync_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reported_q, reported_d;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;
    logic             stuck_err_q, stuck_err_d;

    phase_e lit_ph;
    phase_e succ_ph;
    logic   code_hit, seq_hit, stuck_hit;

    always_comb begin
        lit_ph = PH_SYNC;
        if (light == RED)         lit_ph = PH_RED;
        else if (light == GREEN)  lit_ph = PH_GREEN;
        else if (light == YELLOW) lit_ph = PH_YELLOW;

        case (phase_q)
            PH_RED:    succ_ph = PH_GREEN;
            PH_GREEN:  succ_ph = PH_YELLOW;
            PH_YELLOW: succ_ph = PH_RED;
            default:   succ_ph = PH_SYNC;
        endcase
    end

    always_comb begin
        phase_d    = phase_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        reported_d = reported_q;
        code_hit   = 1'b0;
        seq_hit    = 1'b0;
        stuck_hit  = 1'b0;

        if (lit_ph == PH_SYNC) begin
            code_hit   = 1'b1;
            phase_d    = PH_SYNC;
            dwell_d    = '0;
            reported_d = 1'b0;
        end else if (phase_q == PH_SYNC) begin
            phase_d    = lit_ph;
            dwell_d    = DW_W'(1);
            reported_d = 1'b0;
        end else if (lit_ph == phase_q) begin
            if (dwell_q < DW_W'(MAX_DWELL)) begin
                dwell_d = dwell_q + DW_W'(1);
            end else if (!reported_q) begin
                // only the first overstay cycle of a phase is reported
                stuck_hit  = 1'b1;
                reported_d = 1'b1;
            end
        end else if (lit_ph == succ_ph) begin
            if (phase_q == PH_YELLOW) cnt_d = cnt_q + CNT_W'(1);
            phase_d    = lit_ph;
            dwell_d    = DW_W'(1);
            reported_d = 1'b0;
        end else begin
            seq_hit    = 1'b1;
            phase_d    = lit_ph;
            dwell_d    = DW_W'(1);
            reported_d = 1'b0;
        end

        in_sync_d = (phase_d != PH_SYNC);

`ifdef LAMP_MON_STICKY_EN
        code_err_d  = code_err_q  | code_hit;
        seq_err_d   = seq_err_q   | seq_hit;
        stuck_err_d = stuck_err_q | stuck_hit;
`else
        code_err_d  = code_hit;
        seq_err_d   = seq_hit;
        stuck_err_d = stuck_hit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_SYNC;
            in_sync_q   <= 1'b0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            reported_q  <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            stuck_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            in_sync_q   <= in_sync_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            reported_q  <= reported_d;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
            stuck_err_q <= stuck_err_d;
        end
    end

    assign phase     = phase_q;
    assign in_sync   = in_sync_q;
    assign dwell     = dwell_q;
    assign cycle_cnt = cnt_q;
    assign code_err  = code_err_q;
    assign seq_err   = seq_err_q;
    assign stuck_err = stuck_err_q;

endmodule
